// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered command/response wrapper around the external 8-bit ALU with CCR and branch-condition logic.
// Optional macro CCR_PRESERVE_LOGIC_EN keeps CCR V/C across logical ops (Sel[2]=1).
module alu_op_sequencer #(
  parameter int unsigned RESP_TIMEOUT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [2:0] Cmd_Sel,
  input  logic [7:0] Cmd_A,
  input  logic [7:0] Cmd_B,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [2:0] ALU_Sel,
  input  logic [7:0] ALU_Result,
  input  logic [3:0] ALU_NZVC,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic [7:0] Out_Result,
  output logic [3:0] CCR,
  input  logic [2:0] Cond_Sel,
  output logic       Cond_True,
  output logic       Drop
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam int unsigned CW = RESP_TIMEOUT > 1 ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RESP_TIMEOUT > 0 ? RESP_TIMEOUT - 1 : 0);
  state_t        state_q;
  logic          rdy_q, valid_q, drop_q, expire, unary;
  logic [7:0]    a_q, b_q, res_q;
  logic [2:0]    sel_q;
  logic [3:0]    ccr_q, ccr_d;
  logic [7:0]    conds;
  logic [CW-1:0] cnt_q;
  assign unary  = (Cmd_Sel == 3'b001) || (Cmd_Sel == 3'b011) || (Cmd_Sel == 3'b111);
  assign expire = (RESP_TIMEOUT > 0) && (state_q == RESP) && !Out_Ready && (cnt_q == LAST);
`ifdef CCR_PRESERVE_LOGIC_EN
  assign ccr_d = sel_q[2] ? {ALU_NZVC[3:2], ccr_q[1:0]} : ALU_NZVC;
`else
  assign ccr_d = ALU_NZVC;
`endif
  // bit i of conds is the branch condition selected by Cond_Sel == i
  assign conds = {~ccr_q[0], ccr_q[0], ccr_q[1], ~ccr_q[3], ccr_q[3], ~ccr_q[2], ccr_q[2], 1'b1};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      res_q   <= '0;
      ccr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: if (Cmd_Valid) begin
          a_q     <= Cmd_A;
          b_q     <= unary ? 8'h00 : Cmd_B;
          sel_q   <= Cmd_Sel;
          rdy_q   <= 1'b0;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= ALU_Result;
          ccr_q   <= ccr_d;
          valid_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= RESP;
        end
        RESP: if (Out_Ready || expire) begin
          valid_q <= 1'b0;
          rdy_q   <= 1'b1;
          drop_q  <= !Out_Ready;
          state_q <= IDLE;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Cmd_Ready  = rdy_q;
  assign Out_Valid  = valid_q;
  assign Out_Result = res_q;
  assign CCR        = ccr_q;
  assign Drop       = drop_q;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign ALU_Sel    = sel_q;
  assign Cond_True  = conds[Cond_Sel];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a bench-side ALU, a default DUT and a RESP_TIMEOUT=4 DUT.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  logic cv, cr, ov, ordy, ct, drop, rnd_cond, force_rdy;
  logic [2:0] csel, asel, cond, cond_r, cond_d;
  logic [7:0] ca, cb, aa, ab, ares, ores;
  logic [3:0] anzvc, ccr, ccr_exp;
  logic t_cv, t_cr, t_ov, t_ordy, t_ct, t_drop;
  logic [2:0] t_csel, t_asel;
  logic [7:0] t_ca, t_cb, t_aa, t_ab, t_ares, t_ores;
  logic [3:0] t_anzvc, t_ccr;
  int checks = 0, errors = 0, cyc = 0, hold_n = 0, resp_age = 0;
  bit prev_ov, prev_hs;
  typedef struct { logic [7:0] a, b, res; logic [2:0] sel; logic [3:0] nzvc; int cyc; } exp_t;
  exp_t q[$];
  exp_t cur;
`ifdef CCR_PRESERVE_LOGIC_EN
  localparam logic [3:0] AND_CCR = 4'b0101;
`else
  localparam logic [3:0] AND_CCR = 4'b0100;
`endif
  // Reference ALU: ADD INC SUB DEC AND OR XOR NOT; returns {NZVC, result}
  function automatic logic [11:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    logic [8:0] w;
    logic v;
    v = 1'b0;
    case (s)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
      3'd1: begin w = {1'b0, a} + 9'd1; v = (a == 8'h7F); end
      3'd2: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
      3'd3: begin w = {1'b0, a} - 9'd1; v = (a == 8'h80); end
      3'd4: w = {1'b0, a & b};
      3'd5: w = {1'b0, a | b};
      3'd6: w = {1'b0, a ^ b};
      default: w = {1'b0, ~a};
    endcase
    return {w[7], w[7:0] == 8'h00, v, s[2] ? 1'b0 : w[8], w[7:0]};
  endfunction
  function automatic logic cond_f(input logic [3:0] c, input logic [2:0] s);
    case (s)
      3'd0: return 1'b1;
      3'd1: return c[2];
      3'd2: return !c[2];
      3'd3: return c[3];
      3'd4: return !c[3];
      3'd5: return c[1];
      3'd6: return c[0];
      default: return !c[0];
    endcase
  endfunction
  function automatic bit unary(input logic [2:0] s);
    return s == 3'd1 || s == 3'd3 || s == 3'd7;
  endfunction
  assign {anzvc, ares}     = alu(aa, ab, asel);
  assign {t_anzvc, t_ares} = alu(t_aa, t_ab, t_asel);
  assign cond = rnd_cond ? cond_r : cond_d;
  alu_op_sequencer dut (
    .clock(clock), .reset(reset), .Cmd_Valid(cv), .Cmd_Ready(cr), .Cmd_Sel(csel), .Cmd_A(ca), .Cmd_B(cb),
    .ALU_A(aa), .ALU_B(ab), .ALU_Sel(asel), .ALU_Result(ares), .ALU_NZVC(anzvc),
    .Out_Valid(ov), .Out_Ready(ordy), .Out_Result(ores), .CCR(ccr), .Cond_Sel(cond), .Cond_True(ct), .Drop(drop));
  alu_op_sequencer #(.RESP_TIMEOUT(4)) dut_to (
    .clock(clock), .reset(reset), .Cmd_Valid(t_cv), .Cmd_Ready(t_cr), .Cmd_Sel(t_csel), .Cmd_A(t_ca), .Cmd_B(t_cb),
    .ALU_A(t_aa), .ALU_B(t_ab), .ALU_Sel(t_asel), .ALU_Result(t_ares), .ALU_NZVC(t_anzvc),
    .Out_Valid(t_ov), .Out_Ready(t_ordy), .Out_Result(t_ores), .CCR(t_ccr), .Cond_Sel(cond), .Cond_True(t_ct), .Drop(t_drop));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur", nm);
  endtask
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) begin
    #1;
    resp_age = ov ? resp_age + 1 : 0;
    ordy = (ov && resp_age <= hold_n) ? 1'b0 : (force_rdy || $urandom_range(0, 2) != 0);
    cond_r = 3'($urandom);
  end
  // Monitor: pops the scoreboard when a response appears and checks every cycle
  always @(negedge clock) begin
    if (reset) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
      ccr_exp = 4'h0;
      q.delete();
    end else begin
      if (prev_hs) begin
        chk("hs_next_ready", cr, 1);
        chk("hs_next_valid", ov, 0);
      end
      if (!cr && !ov) begin
        if (q.size() == 0) fail("exec_without_cmd");
        else begin
          chk("exec_alu_a", aa, q[0].a);
          chk("exec_alu_b", ab, q[0].b);
          chk("exec_alu_sel", asel, q[0].sel);
          chk("exec_cycle", cyc, q[0].cyc + 1);
        end
      end
      if (ov && !prev_ov) begin
        if (q.size() == 0) fail("valid_without_cmd");
        else begin
          cur = q.pop_front();
          chk("latency", cyc, cur.cyc + 2);
`ifdef CCR_PRESERVE_LOGIC_EN
          ccr_exp = cur.sel[2] ? {cur.nzvc[3:2], ccr_exp[1:0]} : cur.nzvc;
`else
          ccr_exp = cur.nzvc;
`endif
        end
      end
      if (ov) begin
        chk("out_result", ores, cur.res);
        chk("ready_in_resp", cr, 0);
      end
      chk("ccr", ccr, ccr_exp);
      chk("cond_true", ct, cond_f(ccr_exp, cond));
      chk("drop_main", drop, 0);
      prev_ov = ov;
      prev_hs = ov && ordy;
    end
  end
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, output int acc);
    exp_t e;
    int n;
    n = 0;
    acc = -1;
    cv = 1'b1; ca = a; cb = b; csel = s;
    while (!cr) begin
      @(posedge clock); #1;
      if (++n > 50) begin fail("accept_timeout"); cv = 1'b0; return; end
    end
    e.a = a; e.b = unary(s) ? 8'h00 : b; e.sel = s;
    {e.nzvc, e.res} = alu(a, e.b, s);
    e.cyc = cyc;
    acc = cyc;
    q.push_back(e);
    @(posedge clock); #1;
    cv = 1'b0; ca = 8'($urandom); cb = 8'($urandom); csel = 3'($urandom);
  endtask
  task automatic wait_ov(input bit want, input string nm);
    int n;
    n = 0;
    while (ov !== want) begin
      @(posedge clock); #1;
      if (++n > 40) begin fail(nm); return; end
    end
  endtask
  initial begin
    int c1, c2, acc, nv;
    bit seen;
    logic [11:0] te;
    reset = 1'b1; cv = 1'b0; ca = '0; cb = '0; csel = '0; hold_n = 0; force_rdy = 1'b1; rnd_cond = 1'b0; cond_d = '0;
    t_cv = 1'b0; t_ca = '0; t_cb = '0; t_csel = '0; t_ordy = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    chk("rst_cmd_ready", cr, 1); chk("rst_out_valid", ov, 0); chk("rst_out_result", ores, 0);
    chk("rst_ccr", ccr, 0); chk("rst_alu_a", aa, 0); chk("rst_alu_b", ab, 0); chk("rst_alu_sel", asel, 0); chk("rst_drop", drop, 0);
    reset = 1'b0;
    hold_n = 2;
    issue(8'h7F, 8'h01, 3'd0, acc);
    wait_ov(1, "add_valid");
    chk("add_result", ores, 8'h80); chk("add_ccr", ccr, 4'b1010);
    cond_d = 3'd5; #1 chk("add_cond_v", ct, 1);
    wait_ov(0, "add_done");
    issue(8'h05, 8'h05, 3'd2, acc);
    wait_ov(1, "sub_valid");
    chk("sub_result", ores, 8'h00); chk("sub_ccr", ccr, 4'b0100);
    cond_d = 3'd1; #1 chk("sub_cond_z", ct, 1);
    cond_d = 3'd2; #1 chk("sub_cond_nz", ct, 0);
    wait_ov(0, "sub_done");
    issue(8'hFF, 8'hAA, 3'd1, acc);
    chk("inc_exec_alu_b", ab, 8'h00);
    wait_ov(1, "inc_valid");
    chk("inc_result", ores, 8'h00); chk("inc_ccr", ccr, 4'b0101);
    wait_ov(0, "inc_done");
    hold_n = 5;
    issue(8'h3C, 8'h11, 3'd0, c1);
    issue(8'h01, 8'h02, 3'd6, c2);
    chk("hold_gap", c2 - c1, 8);
    wait_ov(1, "hold2_valid");
    wait_ov(0, "hold2_done");
    hold_n = 0;
    issue(8'hFF, 8'h00, 3'd1, acc);
    wait_ov(1, "pinc_valid");
    chk("pinc_ccr", ccr, 4'b0101);
    wait_ov(0, "pinc_done");
    issue(8'hF0, 8'h0F, 3'd4, acc);
    wait_ov(1, "and_valid");
    chk("and_result", ores, 8'h00); chk("and_ccr", ccr, AND_CCR);
    wait_ov(0, "and_done");
    issue(8'hF0, 8'h0F, 3'd4, acc);
    chk("and2_in_exec", cr, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rexec_ccr", ccr, 0); chk("rexec_valid", ov, 0); chk("rexec_drop", drop, 0); chk("rexec_ready", cr, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rexec_valid_next", ov, 0); chk("rexec_drop_next", drop, 0); chk("rexec_ccr_next", ccr, 0);
    rnd_cond = 1'b1; force_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      issue(8'($urandom), 8'($urandom), 3'($urandom), acc);
    end
    force_rdy = 1'b1;
    for (int i = 0; i < 40 && (q.size() != 0 || ov); i++) begin @(posedge clock); #1; end
    chk("queue_empty", q.size(), 0);
    chk("to_cmd_ready", t_cr, 1);
    t_cv = 1'b1; t_csel = 3'd2; t_ca = 8'h10; t_cb = 8'h30; t_ordy = 1'b0;
    te = alu(8'h10, 8'h30, 3'd2);
    @(posedge clock); #1;
    t_cv = 1'b0;
    nv = 0; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clock); #1;
      if (t_ov) nv++;
      if (t_drop) seen = 1'b1;
    end
    chk("to_drop_seen", seen, 1); chk("to_resp_cycles", nv, 4);
    chk("to_valid_off", t_ov, 0); chk("to_ready", t_cr, 1); chk("to_ccr_kept", t_ccr, te[11:8]);
    @(posedge clock); #1;
    chk("to_drop_once", t_drop, 0); chk("to_ccr_hold", t_ccr, te[11:8]);
    t_cv = 1'b1; t_csel = 3'd0; t_ca = 8'h01; t_cb = 8'h01;
    @(posedge clock); #1;
    t_cv = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    chk("aw_valid4", t_ov, 1);
    t_ordy = 1'b1;
    @(posedge clock); #1;
    t_ordy = 1'b0;
    chk("aw_no_drop", t_drop, 0); chk("aw_done", t_ov, 0); chk("aw_result", t_ores, 8'h02);
    repeat (2) begin @(posedge clock); #1; chk("aw_no_drop_later", t_drop, 0); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
